pipe_stage_buf: RTL and testbench

Parametrised multi-lane pipeline stage register with a valid/ready handshake and an optional skid entry. It replaces the hard-coded dual-lane stage buffers: all lanes move as one bundle, with per-lane kill (bubble insertion), global flush and saturating stall/bubble counters. One instance is placed at each stage boundary (f2/dec, dec/issue, issue/exec, ...); the caller packs inst/ctrl/pc/pred per lane.

---
 rtl/pipe_stage_buf_if.sv | 15 +
 rtl/pipe_stage_buf.sv | 140 ++++++++++++++
 tb/tb_pipe_stage_buf.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready bundle handshake between pipeline stages.
//   valid : per-lane valid of the bundle (producer -> consumer)
//   data  : lane k at [k*DATA_W +: DATA_W]  (producer -> consumer)
//   ready : consumer accepts the bundle      (consumer -> producer)
interface pipe_stage_buf_if #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DATA_W = 96
);
  logic [LANES-1:0]        valid;
  logic [LANES*DATA_W-1:0] data;
  logic                    ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_buf.sv
// Multi-lane pipeline stage register with valid/ready handshake, optional
// skid entry, per-lane kill, global flush and saturating stall/bubble counters.
//   clock_i, reset_n_i : clock, async active-low reset
//   in_if  (slave)     : incoming bundle; in_if.ready = stage can accept
//   out_if (master)    : head bundle, driven straight from the main entry
//   kill_i             : squash lanes of the incoming bundle
//   flush_i            : drop everything held and incoming
//   occupancy_o        : bundles held (0..2)
//   cnt_clr_i          : clear both counters
//   stall_cnt_o        : cycles head valid but not consumed
//   bubble_cnt_o       : cycles downstream ready but no head
module pipe_stage_buf #(
  parameter int unsigned LANES   = 2,
  parameter int unsigned DATA_W  = 96,
  parameter int unsigned SKID_EN = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  pipe_stage_buf_if.slave   in_if,
  pipe_stage_buf_if.master  out_if,
  input  logic [LANES-1:0]  kill_i,
  input  logic              flush_i,
  output logic [1:0]        occupancy_o,
  input  logic              cnt_clr_i,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  localparam int unsigned BW = LANES * DATA_W;

  logic [LANES-1:0] m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic [BW-1:0]    m_data_q,  m_data_d,  s_data_q,  s_data_d;
  logic             in_ready_q, in_ready_d;
  logic [1:0]       occ_q, occ_d;
  logic [CNT_W-1:0] stall_q, stall_d, bubble_q, bubble_d;

  logic [LANES-1:0] ev;
  logic [BW-1:0]    in_masked;
  logic             in_ready, in_fire, out_fire, m_any, s_any;

  // Effective lanes after kill; killed/invalid lanes carry zero payload.
  always_comb begin
    ev        = in_if.valid & ~kill_i;
    in_masked = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      if (ev[k]) in_masked[k*DATA_W +: DATA_W] = in_if.data[k*DATA_W +: DATA_W];
    end
  end

  // Skid variant advertises ready from a flop; single-entry variant lets a
  // consumed head make room in the same cycle.
  always_comb begin
    m_any    = |m_valid_q;
    s_any    = |s_valid_q;
    in_ready = (SKID_EN != 0) ? in_ready_q : (!m_any || out_if.ready);
    in_fire  = in_ready && (|ev);
    out_fire = m_any && out_if.ready;
  end

  // Entry movement, counters and registered status.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    stall_d   = stall_q;
    bubble_d  = bubble_q;

    if (flush_i) begin
      m_valid_d = '0;
      m_data_d  = '0;
      s_valid_d = '0;
      s_data_d  = '0;
    end else if (!m_any) begin
      if (in_fire) begin
        m_valid_d = ev;
        m_data_d  = in_masked;
      end
    end else if (out_fire) begin
      if (s_any) begin
        // Skid full means upstream was held off, so no input this cycle.
        m_valid_d = s_valid_q;
        m_data_d  = s_data_q;
        s_valid_d = '0;
        s_data_d  = '0;
      end else if (in_fire) begin
        m_valid_d = ev;
        m_data_d  = in_masked;
      end else begin
        m_valid_d = '0;
        m_data_d  = '0;
      end
    end else if (in_fire && (SKID_EN != 0)) begin
      s_valid_d = ev;
      s_data_d  = in_masked;
    end

    if (cnt_clr_i) begin
      stall_d  = '0;
      bubble_d = '0;
    end else begin
      if (m_any && !out_if.ready && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
      if (!m_any && out_if.ready && (bubble_q != '1)) bubble_d = bubble_q + CNT_W'(1);
    end

    in_ready_d = !(|s_valid_d);
    occ_d      = 2'(|m_valid_d) + 2'(|s_valid_d);
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      m_valid_q  <= '0;
      m_data_q   <= '0;
      s_valid_q  <= '0;
      s_data_q   <= '0;
      in_ready_q <= 1'b1;
      occ_q      <= '0;
      stall_q    <= '0;
      bubble_q   <= '0;
    end else begin
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      s_valid_q  <= s_valid_d;
      s_data_q   <= s_data_d;
      in_ready_q <= in_ready_d;
      occ_q      <= occ_d;
      stall_q    <= stall_d;
      bubble_q   <= bubble_d;
    end
  end

  assign in_if.ready  = in_ready;
  assign out_if.valid = m_valid_q;
  assign out_if.data  = m_data_q;
  assign occupancy_o  = occ_q;
  assign stall_cnt_o  = stall_q;
  assign bubble_cnt_o = bubble_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a skid instance (a) and a single-entry instance (b)
// share stimulus; a FIFO model of each is compared every cycle, and directed
// literal expectations pin the model.
module tb_pipe_stage_buf;

  logic        clk, rst_n;
  logic [1:0]  in_valid, kill;
  logic [31:0] in_data;
  logic        flush, out_ready, cnt_clr;
  logic [1:0]  occ_a, occ_b;
  logic [3:0]  stall_a, stall_b, bubble_a, bubble_b;

  int n_checks = 0;
  int n_pass   = 0;

  pipe_stage_buf_if #(.LANES(2), .DATA_W(16)) in_a ();
  pipe_stage_buf_if #(.LANES(2), .DATA_W(16)) out_a ();
  pipe_stage_buf_if #(.LANES(2), .DATA_W(16)) in_b ();
  pipe_stage_buf_if #(.LANES(2), .DATA_W(16)) out_b ();

  assign in_a.valid  = in_valid;
  assign in_a.data   = in_data;
  assign out_a.ready = out_ready;
  assign in_b.valid  = in_valid;
  assign in_b.data   = in_data;
  assign out_b.ready = out_ready;

  pipe_stage_buf #(.LANES(2), .DATA_W(16), .SKID_EN(1), .CNT_W(4)) u_a (
    .clock_i(clk), .reset_n_i(rst_n), .in_if(in_a), .out_if(out_a),
    .kill_i(kill), .flush_i(flush), .occupancy_o(occ_a), .cnt_clr_i(cnt_clr),
    .stall_cnt_o(stall_a), .bubble_cnt_o(bubble_a));

  pipe_stage_buf #(.LANES(2), .DATA_W(16), .SKID_EN(0), .CNT_W(4)) u_b (
    .clock_i(clk), .reset_n_i(rst_n), .in_if(in_b), .out_if(out_b),
    .kill_i(kill), .flush_i(flush), .occupancy_o(occ_b), .cnt_clr_i(cnt_clr),
    .stall_cnt_o(stall_b), .bubble_cnt_o(bubble_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: a FIFO of whole bundles, capacity 2 (inst 0) or 1 (inst 1).
  int          mn [2];
  logic [1:0]  mv [2][2];
  logic [31:0] md [2][2];
  logic [3:0]  ms [2];
  logic [3:0]  mb [2];

  function automatic logic model_ready(input int i);
    if (i == 0) return mn[0] < 2;
    return (mn[1] == 0) || out_ready;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mn[i] <= 0; ms[i] <= '0; mb[i] <= '0;
        mv[i][0] <= '0; mv[i][1] <= '0; md[i][0] <= '0; md[i][1] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic [1:0]  v0, v1, ev;
        logic [31:0] d0, d1, dm;
        int          nn;
        ev = in_valid & ~kill;
        dm = {ev[1] ? in_data[31:16] : 16'h0, ev[0] ? in_data[15:0] : 16'h0};
        v0 = mv[i][0]; v1 = mv[i][1]; d0 = md[i][0]; d1 = md[i][1]; nn = mn[i];
        if (flush) begin
          v0 = '0; v1 = '0; d0 = '0; d1 = '0; nn = 0;
        end else begin
          if (nn > 0 && out_ready) begin
            v0 = v1; d0 = d1; v1 = '0; d1 = '0; nn--;
          end
          if (model_ready(i) && (|ev)) begin
            if (nn == 0) begin v0 = ev; d0 = dm; end
            else begin v1 = ev; d1 = dm; end
            nn++;
          end
        end
        mv[i][0] <= v0; mv[i][1] <= v1; md[i][0] <= d0; md[i][1] <= d1; mn[i] <= nn;
        if (cnt_clr) begin
          ms[i] <= '0; mb[i] <= '0;
        end else begin
          if (mn[i] > 0 && !out_ready && ms[i] != 4'hF) ms[i] <= ms[i] + 4'd1;
          if (mn[i] == 0 && out_ready && mb[i] != 4'hF) mb[i] <= mb[i] + 4'd1;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("a_out_valid", 32'(out_a.valid), 32'(mv[0][0]));
      chk("a_out_data",  out_a.data,       md[0][0]);
      chk("a_in_ready",  32'(in_a.ready),  32'(model_ready(0)));
      chk("a_occupancy", 32'(occ_a),       32'(mn[0]));
      chk("a_stall_cnt", 32'(stall_a),     32'(ms[0]));
      chk("a_bubble_cnt",32'(bubble_a),    32'(mb[0]));
      chk("b_out_valid", 32'(out_b.valid), 32'(mv[1][0]));
      chk("b_out_data",  out_b.data,       md[1][0]);
      chk("b_in_ready",  32'(in_b.ready),  32'(model_ready(1)));
      chk("b_occupancy", 32'(occ_b),       32'(mn[1]));
      chk("b_stall_cnt", 32'(stall_b),     32'(ms[1]));
      chk("b_bubble_cnt",32'(bubble_b),    32'(mb[1]));
    end
  end

  task automatic drive(input logic [1:0] v, input logic [31:0] d, input logic [1:0] k,
                       input logic f, input logic r, input logic c);
    in_valid = v; in_data = d; kill = k; flush = f; out_ready = r; cnt_clr = c;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] AB = 32'h2222_1111;
  localparam logic [31:0] X  = 32'h0A0A_0B0B;
  localparam logic [31:0] Y  = 32'h1C1C_1D1D;
  localparam logic [31:0] Z  = 32'h2E2E_2F2F;
  localparam logic [31:0] P  = 32'h3131_3232;
  localparam logic [31:0] Q  = 32'h4343_4444;
  localparam logic [31:0] R  = 32'h5555_5656;

  initial begin
    rst_n = 1'b0; in_valid = '0; in_data = '0; kill = '0;
    flush = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_a.valid), 32'h0);
    chk("rst_occ",   32'(occ_a),       32'h0);
    chk("rst_ready", 32'(in_a.ready),  32'h1);
    chk("rst_stall", 32'(stall_a),     32'h0);
    rst_n = 1'b1;

    // Straight-through bundle with downstream always ready.
    drive(2'b11, AB, 2'b00, 1'b0, 1'b1, 1'b1);
    chk("pass_valid",  32'(out_a.valid), 32'h3);
    chk("pass_data",   out_a.data,       AB);
    chk("pass_occ",    32'(occ_a),       32'h1);
    chk("pass_bubble", 32'(bubble_a),    32'h0);
    drive(2'b00, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("drain_valid", 32'(out_a.valid), 32'h0);
    chk("drain_stall", 32'(stall_a),     32'h0);

    // Backpressure: X in main, Y in skid, Z held upstream.
    drive(2'b11, X, 2'b00, 1'b0, 1'b0, 1'b0);
    drive(2'b11, Y, 2'b00, 1'b0, 1'b0, 1'b0);
    drive(2'b11, Z, 2'b00, 1'b0, 1'b0, 1'b0);
    drive(2'b11, Z, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("bp_data",    out_a.data,       X);
    chk("bp_occ",     32'(occ_a),       32'h2);
    chk("bp_ready",   32'(in_a.ready),  32'h0);
    chk("bp_stall",   32'(stall_a),     32'h3);
    chk("bp_b_occ",   32'(occ_b),       32'h1);
    chk("bp_b_ready", 32'(in_b.ready),  32'h0);
    drive(2'b11, Z, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("rel_y",     out_a.data,       Y);
    chk("rel_ready", 32'(in_a.ready),  32'h1);
    drive(2'b11, Z, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("rel_z",     out_a.data,       Z);
    chk("rel_occ",   32'(occ_a),       32'h1);
    drive(2'b00, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0);

    // Per-lane kill, then full kill.
    drive(2'b11, 32'hCCCC_DDDD, 2'b10, 1'b0, 1'b1, 1'b0);
    chk("kill_valid",  32'(out_a.valid), 32'h1);
    chk("kill_data",   out_a.data,       32'h0000_DDDD);
    chk("kill_bubble", 32'(bubble_a),    32'h1);
    drive(2'b11, 32'hCCCC_DDDD, 2'b11, 1'b0, 1'b1, 1'b0);
    chk("killall_valid", 32'(out_a.valid), 32'h0);
    drive(2'b00, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("killall_bubble", 32'(bubble_a), 32'h2);

    // Flush with both entries full and a valid input in the same cycle.
    drive(2'b11, P, 2'b00, 1'b0, 1'b0, 1'b0);
    drive(2'b11, Q, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("pre_flush_occ", 32'(occ_a), 32'h2);
    drive(2'b11, R, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("flush_occ",   32'(occ_a),       32'h0);
    chk("flush_valid", 32'(out_a.valid), 32'h0);
    chk("flush_stall", 32'(stall_a),     32'h5);
    drive(2'b00, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("flush_no_r", 32'(out_a.valid), 32'h0);

    // Asynchronous reset with both entries full.
    drive(2'b11, P, 2'b00, 1'b0, 1'b0, 1'b0);
    drive(2'b11, Q, 2'b00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("mrst_valid",  32'(out_a.valid), 32'h0);
    chk("mrst_occ",    32'(occ_a),       32'h0);
    chk("mrst_ready",  32'(in_a.ready),  32'h1);
    chk("mrst_stall",  32'(stall_a),     32'h0);
    chk("mrst_bubble", 32'(bubble_a),    32'h0);
    in_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Bubble counter saturation and clear priority.
    for (int n = 0; n < 20; n++) drive(2'b00, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("sat_bubble",   32'(bubble_a), 32'hF);
    chk("sat_bubble_b", 32'(bubble_b), 32'hF);
    drive(2'b00, 32'h0, 2'b00, 1'b0, 1'b1, 1'b1);
    chk("clr_bubble", 32'(bubble_a), 32'h0);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
